// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for the router ingress slice
// Purpose : FSM state encoding, header field widths, the reserved address
//           value and a small per-port flag select helper.
// Ports   : none (package).
package router_pkg;

  localparam int BYTE_W = 8;
  localparam int LEN_W  = 6;
  localparam int ADDR_W = 2;
  localparam int NPORT  = 3;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    WAIT_TILL_EMPTY    = 3'd1,
    LOAD_FIRST_DATA    = 3'd2,
    LOAD_DATA          = 3'd3,
    LOAD_PARITY        = 3'd4,
    CHECK_PARITY_ERROR = 3'd5
  } state_t;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [BYTE_W-1:0] hdr);
    return hdr[7:2];
  endfunction

  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [BYTE_W-1:0] hdr);
    return hdr[1:0];
  endfunction

  // Pick one port's flag; the reserved address reads as 0 so it can never
  // look like an empty FIFO or a soft reset request.
  function automatic logic sel_port(input logic [NPORT-1:0] v,
                                    input logic [ADDR_W-1:0] a);
    case (a)
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/router_parity_chk.sv
// rtl/router_parity_chk.sv - running packet parity and error flag
// Purpose : XOR-accumulates header and payload, latches the trailing parity
//           byte and registers the mismatch as err.
// Ports   : clock, resetn       - clock, async active-low reset
//           hdr_load            - header accepted: restart accumulator, clear err
//           payload_load        - payload byte accepted: fold into accumulator
//           parity_load         - parity byte accepted: latch it
//           check_en            - compare accumulator with latched parity
//           data_in             - byte being accepted
//           err                 - parity mismatch of last completed packet
module router_parity_chk
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              hdr_load,
  input  logic              payload_load,
  input  logic              parity_load,
  input  logic              check_en,
  input  logic [BYTE_W-1:0] data_in,
  output logic              err
);

  logic [BYTE_W-1:0] parity_acc;
  logic [BYTE_W-1:0] pkt_parity;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      parity_acc <= '0;
      pkt_parity <= '0;
      err        <= 1'b0;
    end else begin
      if (hdr_load)
        parity_acc <= data_in;
      else if (payload_load)
        parity_acc <= parity_acc ^ data_in;

      if (parity_load)
        pkt_parity <= data_in;

      // err is sticky across idle time and aborted packets; only a new
      // accepted header clears it.
      if (hdr_load)
        err <= 1'b0;
      else if (check_en)
        err <= (parity_acc != pkt_parity);
    end
  end

endmodule

// File: rtl/router_ingress.sv
// rtl/router_ingress.sv - packet ingress FSM steering bytes into 3 output FIFOs
// Purpose : decodes {len,addr} header, waits for the target FIFO to drain,
//           writes header, payload and parity to it, checks parity.
// Ports   : clock, resetn            - clock, async active-low reset
//           pkt_valid, data_in       - source byte stream
//           fifo_full, fifo_empty    - per-FIFO status
//           soft_reset               - per-FIFO abort request
//           write_enb, dout          - one-hot write strobe and byte to FIFOs
//           lfd_state                - marks the header write
//           busy                     - source must hold its byte while high
//           err, parity_done         - parity result and completion pulse
module router_ingress
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [BYTE_W-1:0] data_in,
  input  logic [NPORT-1:0]  fifo_full,
  input  logic [NPORT-1:0]  fifo_empty,
  input  logic [NPORT-1:0]  soft_reset,
  output logic [NPORT-1:0]  write_enb,
  output logic [BYTE_W-1:0] dout,
  output logic              lfd_state,
  output logic              busy,
  output logic              err,
  output logic              parity_done
);

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  addr;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   remaining;
  logic [BYTE_W-1:0]  hdr_reg;

  logic               full_sel;
  logic               empty_sel;
  logic               abort;
  logic               accept;
  logic               hdr_ok;
  logic               hdr_take;
  logic               payload_take;
  logic               parity_take;
  logic               check_en;
  logic [NPORT-1:0]   port_onehot;

  assign full_sel    = sel_port(fifo_full, addr);
  assign empty_sel   = sel_port(fifo_empty, addr);
  assign port_onehot = 3'b001 << addr;

  // Only the soft reset of the port currently being fed matters, and only
  // once a packet is in flight.
  assign abort  = (state != DECODE_ADDRESS) && sel_port(soft_reset, addr);

  always_comb begin
    busy = 1'b1;
    case (state)
      DECODE_ADDRESS:         busy = 1'b0;
      LOAD_DATA, LOAD_PARITY: busy = full_sel;
      default:                busy = 1'b1;
    endcase
  end

  assign accept       = pkt_valid && !busy;
  assign hdr_ok       = hdr_addr(data_in) != ADDR_INVALID;
  assign hdr_take     = (state == DECODE_ADDRESS) && accept && hdr_ok;
  assign payload_take = (state == LOAD_DATA) && accept && !abort;
  assign parity_take  = (state == LOAD_PARITY) && accept && !abort;
  assign check_en     = (state == CHECK_PARITY_ERROR) && !abort;

  always_comb begin
    write_enb   = '0;
    dout        = '0;
    lfd_state   = 1'b0;
    parity_done = 1'b0;
    if (!abort) begin
      case (state)
        LOAD_FIRST_DATA: begin
          write_enb = port_onehot;
          dout      = hdr_reg;
          lfd_state = 1'b1;
        end
        LOAD_DATA, LOAD_PARITY: begin
          if (accept) begin
            write_enb = port_onehot;
            dout      = data_in;
          end
        end
        CHECK_PARITY_ERROR: parity_done = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS:
          if (hdr_take)
            state_nxt = sel_port(fifo_empty, hdr_addr(data_in)) ? LOAD_FIRST_DATA
                                                                : WAIT_TILL_EMPTY;
        WAIT_TILL_EMPTY:
          if (empty_sel) state_nxt = LOAD_FIRST_DATA;
        LOAD_FIRST_DATA:
          state_nxt = (len != '0) ? LOAD_DATA : LOAD_PARITY;
        LOAD_DATA:
          if (payload_take && remaining == 6'd1) state_nxt = LOAD_PARITY;
        LOAD_PARITY:
          if (parity_take) state_nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          state_nxt = DECODE_ADDRESS;
        default:
          state_nxt = DECODE_ADDRESS;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= DECODE_ADDRESS;
      addr      <= '0;
      len       <= '0;
      remaining <= '0;
      hdr_reg   <= '0;
    end else begin
      state <= state_nxt;
      if (hdr_take) begin
        addr      <= hdr_addr(data_in);
        len       <= hdr_len(data_in);
        remaining <= hdr_len(data_in);
        hdr_reg   <= data_in;
      end else if (payload_take) begin
        remaining <= remaining - 6'd1;
      end
    end
  end

  router_parity_chk u_parity_chk (
    .clock        (clock),
    .resetn       (resetn),
    .hdr_load     (hdr_take),
    .payload_load (payload_take),
    .parity_load  (parity_take),
    .check_en     (check_en),
    .data_in      (data_in),
    .err          (err)
  );

endmodule

// File: tb/tb_router_ingress.sv
// tb/tb_router_ingress.sv - directed self-checking bench for router_ingress
module tb_router_ingress;

  logic       clock;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic [2:0] write_enb;
  logic [7:0] dout;
  logic       lfd_state;
  logic       busy;
  logic       err;
  logic       parity_done;

  int tests = 0;
  int fails = 0;

  logic [7:0] pkt      [0:69];
  int         wr_n;
  logic [2:0] wr_en    [0:99];
  logic [7:0] wr_dat   [0:99];
  logic       wr_lfd   [0:99];
  int         wr_cyc   [0:99];
  logic       busy_hist[0:299];
  int         pd_cnt;
  int         full_busy;
  int         full_wr;
  int         timed_out;

  router_ingress dut (
    .clock       (clock),
    .resetn      (resetn),
    .pkt_valid   (pkt_valid),
    .data_in     (data_in),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .soft_reset  (soft_reset),
    .write_enb   (write_enb),
    .dout        (dout),
    .lfd_state   (lfd_state),
    .busy        (busy),
    .err         (err),
    .parity_done (parity_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Fills pkt[] with header, nlen payload bytes (seed+1, seed+2, ...) and the
  // XOR parity byte, optionally corrupted.
  task automatic build_pkt(input logic [7:0] hdr, input int nlen,
                           input logic [7:0] seed, input logic [7:0] corrupt);
    logic [7:0] p;
    pkt[0] = hdr;
    p = hdr;
    for (int i = 1; i <= nlen; i++) begin
      pkt[i] = seed + 8'(i);
      p = p ^ pkt[i];
    end
    pkt[nlen+1] = p ^ corrupt;
  endtask

  // Source that honours busy; records every FIFO write. Entered and left at
  // posedge+1; outputs are sampled at the falling edge.
  task automatic run_pkt(input int n, input logic [1:0] port,
                         input int full_at, input int full_cycles,
                         input int empty_delay, input logic [2:0] soft_bg,
                         input int soft_at);
    int   idx;
    int   cyc;
    int   stall;
    logic acc;
    logic done;
    logic sr;
    wr_n = 0; pd_cnt = 0; full_busy = 0; full_wr = 0; timed_out = 0;
    idx = 0; cyc = 0; stall = 0; done = 1'b0;
    while (!done) begin
      pkt_valid  = (idx < n);
      data_in    = (idx < n) ? pkt[idx] : 8'h00;
      fifo_empty = 3'b111;
      if (cyc < empty_delay) fifo_empty[port] = 1'b0;
      fifo_full = 3'b000;
      if (idx == full_at && stall < full_cycles) begin
        fifo_full[port] = 1'b1;
        stall++;
      end
      sr = (soft_at >= 0) && (idx == soft_at);
      soft_reset = soft_bg;
      if (sr) soft_reset[port] = 1'b1;
      #4;
      busy_hist[cyc] = busy;
      if (fifo_full[port]) begin
        if (busy) full_busy++;
        if (write_enb != 3'b000) full_wr++;
      end
      if (write_enb != 3'b000 && wr_n < 100) begin
        wr_en[wr_n]  = write_enb;
        wr_dat[wr_n] = dout;
        wr_lfd[wr_n] = lfd_state;
        wr_cyc[wr_n] = cyc;
        wr_n++;
      end
      if (parity_done) begin
        pd_cnt++;
        done = 1'b1;
      end
      acc = pkt_valid && !busy;
      @(posedge clock); #1;
      if (acc) idx++;
      cyc++;
      if (sr) done = 1'b1;
      if (cyc >= 300) begin
        timed_out = 1;
        done = 1'b1;
      end
    end
    pkt_valid = 1'b0; data_in = 8'h00; soft_reset = 3'b000;
    fifo_full = 3'b000; fifo_empty = 3'b111;
  endtask

  task automatic test_reset();
    resetn = 1'b0; pkt_valid = 1'b1; data_in = 8'h39;
    fifo_full = 3'b000; fifo_empty = 3'b111; soft_reset = 3'b000;
    #2;
    tests++;
    if ({write_enb, dout, lfd_state, busy, err, parity_done} !== 15'h0) begin
      fails++;
      $display("FAIL reset_outputs: got we=%b dout=%h lfd=%b busy=%b err=%b pd=%b required all 0",
               write_enb, dout, lfd_state, busy, err, parity_done);
    end
    @(posedge clock); #1;
    tests++;
    if (write_enb !== 3'b000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_held: got we=%b busy=%b required 000/0", write_enb, busy);
    end
    pkt_valid = 1'b0; data_in = 8'h00;
    resetn = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    build_pkt(8'h39, 14, 8'h10, 8'h00);
    run_pkt(16, 2'd1, -1, 0, 0, 3'b000, -1);
    tests++;
    if (timed_out != 0) begin fails++; $display("FAIL basic_timeout: got %0d required 0", timed_out); end
    tests++;
    if (wr_n != 16) begin fails++; $display("FAIL basic_write_count: got %0d required 16", wr_n); end
    for (int i = 0; i < 16 && i < wr_n; i++) begin
      tests++;
      if (wr_en[i] !== 3'b010 || wr_dat[i] !== pkt[i] || wr_lfd[i] !== (i == 0)) begin
        fails++;
        $display("FAIL basic_write[%0d]: got we=%b d=%h lfd=%b required 010/%h/%b",
                 i, wr_en[i], wr_dat[i], wr_lfd[i], pkt[i], (i == 0));
      end
    end
    tests++;
    if ((wr_n > 15 ? wr_cyc[15] : -1) != 16) begin
      fails++; $display("FAIL basic_parity_cycle: got %0d required 16", wr_n > 15 ? wr_cyc[15] : -1);
    end
    tests++;
    if (pd_cnt != 1 || err !== 1'b0) begin
      fails++; $display("FAIL basic_done_err: got pd=%0d err=%b required 1/0", pd_cnt, err);
    end
  endtask

  task automatic test_stall();
    build_pkt(8'h39, 14, 8'h40, 8'h00);
    run_pkt(16, 2'd1, 6, 3, 0, 3'b101, -1);
    tests++;
    if (wr_n != 16) begin fails++; $display("FAIL stall_write_count: got %0d required 16", wr_n); end
    for (int i = 0; i < 16 && i < wr_n; i++) begin
      tests++;
      if (wr_en[i] !== 3'b010 || wr_dat[i] !== pkt[i]) begin
        fails++;
        $display("FAIL stall_write[%0d]: got we=%b d=%h required 010/%h", i, wr_en[i], wr_dat[i], pkt[i]);
      end
    end
    tests++;
    if (full_busy != 3 || full_wr != 0) begin
      fails++; $display("FAIL stall_busy: got busy=%0d writes=%0d required 3/0", full_busy, full_wr);
    end
    tests++;
    if ((wr_n > 15 ? wr_cyc[15] : -1) != 19) begin
      fails++; $display("FAIL stall_parity_cycle: got %0d required 19", wr_n > 15 ? wr_cyc[15] : -1);
    end
    tests++;
    if (pd_cnt != 1 || err !== 1'b0) begin
      fails++; $display("FAIL stall_done_err: got pd=%0d err=%b required 1/0", pd_cnt, err);
    end
  endtask

  task automatic test_parity_error();
    build_pkt(8'h39, 14, 8'h20, 8'h01);
    run_pkt(16, 2'd1, -1, 0, 0, 3'b000, -1);
    tests++;
    if (wr_n != 16 || pd_cnt != 1) begin
      fails++; $display("FAIL perr_counts: got writes=%0d pd=%0d required 16/1", wr_n, pd_cnt);
    end
    for (int c = 0; c < 2; c++) begin
      #4;
      tests++;
      if (err !== 1'b1) begin fails++; $display("FAIL perr_err_held[%0d]: got %b required 1", c, err); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_invalid_and_len0();
    pkt_valid = 1'b1; data_in = 8'h0F;
    #4;
    tests++;
    if (write_enb !== 3'b000 || busy !== 1'b0) begin
      fails++; $display("FAIL addr3_accept: got we=%b busy=%b required 000/0", write_enb, busy);
    end
    @(posedge clock); #1;
    pkt_valid = 1'b0; data_in = 8'h00;
    #4;
    tests++;
    if (write_enb !== 3'b000 || busy !== 1'b0 || err !== 1'b1) begin
      fails++; $display("FAIL addr3_after: got we=%b busy=%b err=%b required 000/0/1", write_enb, busy, err);
    end
    @(posedge clock); #1;
    build_pkt(8'h00, 0, 8'h00, 8'h00);
    run_pkt(2, 2'd0, -1, 0, 0, 3'b000, -1);
    tests++;
    if (wr_n != 2) begin fails++; $display("FAIL len0_write_count: got %0d required 2", wr_n); end
    tests++;
    if (wr_n == 2 && (wr_en[0] !== 3'b001 || wr_lfd[0] !== 1'b1 || wr_en[1] !== 3'b001 || wr_lfd[1] !== 1'b0)) begin
      fails++; $display("FAIL len0_writes: got we=%b/%b lfd=%b/%b required 001/001 1/0",
                        wr_en[0], wr_en[1], wr_lfd[0], wr_lfd[1]);
    end
    tests++;
    if (pd_cnt != 1 || err !== 1'b0) begin
      fails++; $display("FAIL len0_done_err: got pd=%0d err=%b required 1/0", pd_cnt, err);
    end
  endtask

  task automatic test_wait_empty();
    build_pkt(8'h06, 1, 8'h5A, 8'h00);
    run_pkt(3, 2'd2, -1, 0, 4, 3'b000, -1);
    tests++;
    if (wr_n != 3) begin fails++; $display("FAIL wait_write_count: got %0d required 3", wr_n); end
    for (int i = 0; i < 3 && i < wr_n; i++) begin
      tests++;
      if (wr_en[i] !== 3'b100 || wr_dat[i] !== pkt[i]) begin
        fails++; $display("FAIL wait_write[%0d]: got we=%b d=%h required 100/%h", i, wr_en[i], wr_dat[i], pkt[i]);
      end
    end
    tests++;
    if ((wr_n > 0 ? wr_cyc[0] : -1) != 5) begin
      fails++; $display("FAIL wait_hdr_cycle: got %0d required 5", wr_n > 0 ? wr_cyc[0] : -1);
    end
    for (int c = 1; c <= 3; c++) begin
      tests++;
      if (busy_hist[c] !== 1'b1) begin fails++; $display("FAIL wait_busy[%0d]: got %b required 1", c, busy_hist[c]); end
    end
    tests++;
    if (pd_cnt != 1) begin fails++; $display("FAIL wait_done: got %0d required 1", pd_cnt); end
  endtask

  task automatic test_soft_reset();
    build_pkt(8'h39, 14, 8'h30, 8'h00);
    run_pkt(16, 2'd1, -1, 0, 0, 3'b000, 5);
    tests++;
    if (wr_n != 5 || pd_cnt != 0 || timed_out != 0) begin
      fails++; $display("FAIL soft_counts: got writes=%0d pd=%0d to=%0d required 5/0/0", wr_n, pd_cnt, timed_out);
    end
    tests++;
    if (wr_n == 5 && wr_dat[4] !== pkt[4]) begin
      fails++; $display("FAIL soft_last_byte: got %h required %h", wr_dat[4], pkt[4]);
    end
    for (int c = 0; c < 3; c++) begin
      #4;
      tests++;
      if (write_enb !== 3'b000 || busy !== 1'b0 || parity_done !== 1'b0) begin
        fails++; $display("FAIL soft_idle[%0d]: got we=%b busy=%b pd=%b required 000/0/0", c, write_enb, busy, parity_done);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_max_len();
    build_pkt(8'hFC, 63, 8'h80, 8'h00);
    run_pkt(65, 2'd0, -1, 0, 0, 3'b000, -1);
    tests++;
    if (wr_n != 65) begin fails++; $display("FAIL max_write_count: got %0d required 65", wr_n); end
    tests++;
    if (wr_n == 65 && (wr_dat[64] !== pkt[64] || wr_lfd[64] !== 1'b0 || wr_en[64] !== 3'b001)) begin
      fails++; $display("FAIL max_parity_write: got d=%h lfd=%b we=%b required %h/0/001", wr_dat[64], wr_lfd[64], wr_en[64], pkt[64]);
    end
    tests++;
    if (pd_cnt != 1 || err !== 1'b0) begin
      fails++; $display("FAIL max_done_err: got pd=%0d err=%b required 1/0", pd_cnt, err);
    end
  endtask

  task automatic test_async_reset();
    fifo_empty = 3'b111;
    pkt_valid = 1'b1; data_in = 8'h39;
    @(posedge clock); #1;
    data_in = 8'h10;
    @(posedge clock); #1;
    #1;
    tests++;
    if (write_enb !== 3'b010) begin fails++; $display("FAIL arst_pre_write: got %b required 010", write_enb); end
    resetn = 1'b0;
    #1;
    tests++;
    if ({write_enb, dout, lfd_state, busy, parity_done} !== 14'h0) begin
      fails++; $display("FAIL arst_outputs: got we=%b dout=%h lfd=%b busy=%b pd=%b required all 0",
                        write_enb, dout, lfd_state, busy, parity_done);
    end
    @(posedge clock); #1;
    resetn = 1'b1; pkt_valid = 1'b0; data_in = 8'h00;
    for (int c = 0; c < 2; c++) begin
      #4;
      tests++;
      if (write_enb !== 3'b000 || busy !== 1'b0) begin
        fails++; $display("FAIL arst_after[%0d]: got we=%b busy=%b required 000/0", c, write_enb, busy);
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_parity_error();
    test_invalid_and_len0();
    test_wait_empty();
    test_soft_reset();
    test_max_len();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/router_ingress.md
ROUTER_INGRESS -- requirements
Module: router_ingress

Interface
REQ-001 Parameter: none; byte width 8, header {len[7:2], addr[1:0]} fixed.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 pkt_valid  input  1  source presents a valid byte on data_in.
REQ-005 data_in  input  8  packet byte stream: header, len payload bytes, parity byte.
REQ-006 fifo_full  input  3  full flag of output FIFOs 0..2.
REQ-007 fifo_empty  input  3  empty flag of output FIFOs 0..2.
REQ-008 soft_reset  input  3  per-FIFO timeout soft reset.
REQ-009 write_enb  output  3  one-hot FIFO write strobe.
REQ-010 dout  output  8  byte to FIFOs (shared data_in bus).
REQ-011 lfd_state  output  1  high with header write; FIFO tags the header.
REQ-012 busy  output  1  source SHALL hold data_in/pkt_valid while high.
REQ-013 err  output  1  parity mismatch of last completed packet.
REQ-014 parity_done  output  1  one-cycle pulse on packet completion.

Function
REQ-015 Byte accepted on rising edge iff pkt_valid=1 and busy=0.
REQ-016 busy: 0 in DECODE_ADDRESS; in LOAD_DATA/LOAD_PARITY = fifo_full[addr]; 1 in WAIT_TILL_EMPTY, LOAD_FIRST_DATA, CHECK_PARITY_ERROR.
REQ-017 write_enb, dout, lfd_state: combinational from state, data_in, fifo_full, pkt_valid; when no write, write_enb=3'b000, dout=8'h00, lfd_state=0.
REQ-018 DECODE_ADDRESS: header accepted; addr=2'b11 -> discarded, stay; else latch addr, len, hdr_reg; parity_acc<=header; err<=0; next LOAD_FIRST_DATA if fifo_empty[addr], else WAIT_TILL_EMPTY.
REQ-019 WAIT_TILL_EMPTY: -> LOAD_FIRST_DATA when fifo_empty[addr]=1.
REQ-020 LOAD_FIRST_DATA: write_enb[addr]=1, dout=hdr_reg, lfd_state=1 for exactly one cycle; next LOAD_DATA if len>0, else LOAD_PARITY.
REQ-021 LOAD_DATA: each accepted byte -> write_enb[addr]=1, dout=data_in, parity_acc^=data_in, remaining-1; after len-th byte -> LOAD_PARITY.
REQ-022 LOAD_DATA with pkt_valid=0 or fifo_full[addr]=1: no write, no count change, stay.
REQ-023 LOAD_PARITY: accepted byte written to FIFO and latched as pkt_parity; -> CHECK_PARITY_ERROR.
REQ-024 CHECK_PARITY_ERROR: err<=(parity_acc!=pkt_parity); parity_done=1 this cycle; -> DECODE_ADDRESS.
REQ-025 err holds until next valid header accepted.
REQ-026 soft_reset[addr]=1 in any state except DECODE_ADDRESS: abort to DECODE_ADDRESS next edge, no write that cycle, err unchanged, parity_done not pulsed; soft_reset of other ports ignored.
REQ-027 Max packet: len=63 -> 65 FIFO writes (header+63+parity); remaining counter 6 bits, no wrap.

Reset
REQ-028 resetn=0 asynchronously: state=DECODE_ADDRESS, addr=0, len/remaining=0, hdr_reg/parity_acc/pkt_parity=8'h00, err=0, parity_done=0; outputs thus write_enb=0, dout=0, lfd_state=0, busy=0.
REQ-029 Reset mid-packet discards packet; no further writes until a new header.

Structure
REQ-030 Shared package router_pkg: state enum (6 states above), ADDR_INVALID=2'b11, header field widths.
REQ-031 One sub-module router_parity_chk: parity accumulator, pkt_parity latch, err register.

Verification
REQ-032 Header 8'h39 (len 14, addr 1), FIFO1 empty, 14 payload, correct parity -> 16 writes on write_enb=3'b010, lfd_state with first only, parity_done pulse, err=0.
REQ-033 Same packet, parity byte XOR 8'h01 -> err=1 after CHECK_PARITY_ERROR, held until next header.
REQ-034 fifo_full[1]=1 after 5th payload for 3 cycles -> busy=1 for those 3 cycles, no writes, no duplicate/lost bytes.
REQ-035 Header 8'h06 (len 1, addr 2) with fifo_empty[2]=0 for 4 cycles -> WAIT_TILL_EMPTY, busy=1, header write 1 cycle after empty rises.
REQ-036 Header 8'h0F (addr 3) -> no write, busy=0, stay DECODE_ADDRESS; header 8'h00 (len 0, addr 0) -> header+parity only.
REQ-037 soft_reset[1] mid-payload -> back to DECODE_ADDRESS, writes stop; resetn low mid-packet -> all outputs 0 immediately.
